// File: rtl/breakout_pkg.sv
// Shared breakout definitions: brick-wall geometry, palette and brick-field state encoding.
package breakout_pkg;

  localparam int NUM_X      = 14;
  localparam int NUM_Y      = 4;
  localparam int BRICK_W    = 40;
  localparam int BRICK_H    = 20;
  localparam int SPACING    = 5;
  localparam int START_X    = 152;
  localparam int START_Y    = 150;
  localparam int NUM_BRICKS = NUM_X * NUM_Y;

  localparam logic [11:0] BLACK  = 12'h000;
  localparam logic [11:0] WHITE  = 12'hFFF;
  localparam logic [11:0] RED    = 12'hF00;
  localparam logic [11:0] ORANGE = 12'hF80;
  localparam logic [11:0] YELLOW = 12'hFF0;
  localparam logic [11:0] GREEN  = 12'h0F0;

  typedef enum logic [1:0] {
    PLAY   = 2'd0,
    FLASH  = 2'd1,
    REFILL = 2'd2
  } brick_state_t;

  function automatic logic [11:0] row_colour(input logic [1:0] row);
    case (row)
      2'd0:    return RED;
      2'd1:    return ORANGE;
      2'd2:    return YELLOW;
      default: return GREEN;
    endcase
  endfunction

endpackage

// File: rtl/brick_locator.sv
// Pure combinational hit-test of a screen coordinate against the brick grid.
module brick_locator
  import breakout_pkg::*;
(
  input  logic [9:0] hCount,
  input  logic [9:0] vCount,
  output logic       in_brick,
  output logic [1:0] row,
  output logic [3:0] col
);

  logic [NUM_X-1:0] col_hit;
  logic [NUM_Y-1:0] row_hit;

  // Every brick edge is a constant, so each column/row is a pair of compares.
  for (genvar gi = 0; gi < NUM_X; gi++) begin : g_col
    localparam int LEFT = START_X + gi * (BRICK_W + SPACING);
    assign col_hit[gi] = (hCount >= 10'(LEFT)) && (hCount < 10'(LEFT + BRICK_W));
  end

  for (genvar gi = 0; gi < NUM_Y; gi++) begin : g_row
    localparam int TOP = START_Y + gi * (BRICK_H + SPACING);
    assign row_hit[gi] = (vCount >= 10'(TOP)) && (vCount < 10'(TOP + BRICK_H));
  end

  always_comb begin
    col = '0;
    row = '0;
    for (int i = 0; i < NUM_X; i++) if (col_hit[i]) col = 4'(i);
    for (int i = 0; i < NUM_Y; i++) if (row_hit[i]) row = 2'(i);
    in_brick = (|col_hit) && (|row_hit);
  end

endmodule

// File: rtl/brick_field.sv
// Brick-wall state: visibility mask, hit handling, pixel rendering and the
// flash-then-refill sequence that follows a cleared level.
module brick_field
  import breakout_pkg::*;
#(
  parameter int FLASH_FRAMES = 60,
  parameter int BLINK_SHIFT  = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [9:0]            hCount,
  input  logic [9:0]            vCount,
  input  logic                  hit_valid,
  input  logic [5:0]            hit_idx,
  output logic [NUM_BRICKS-1:0] visible,
  output logic                  brick_on,
  output logic [11:0]           brick_pixel,
  output logic [5:0]            bricks_left,
  output logic                  level_clear
);

  localparam int FC_W = $clog2(FLASH_FRAMES);

  brick_state_t          state_reg, state_next;
  logic [FC_W-1:0]       frame_cnt_reg, frame_cnt_next;
  logic [NUM_BRICKS-1:0] visible_reg, visible_next;
  logic [5:0]            bricks_left_reg, bricks_left_next;
  logic                  level_clear_reg;
  logic                  brick_on_reg;
  logic [11:0]           brick_pixel_reg;

  logic [63:0] vis_ext;
  logic        frame_start;
  logic        hit_accept;
  logic        in_brick;
  logic [1:0]  loc_row;
  logic [3:0]  loc_col;
  logic [5:0]  pix_idx;
  logic        draw_next;
  logic [11:0] colour_next;

  brick_locator u_locator (
    .hCount   (hCount),
    .vCount   (vCount),
    .in_brick (in_brick),
    .row      (loc_row),
    .col      (loc_col)
  );

  // Zero-padded so any 6-bit index reads safely; padding bits read as absent.
  assign vis_ext     = {{(64 - NUM_BRICKS){1'b0}}, visible_reg};
  assign frame_start = (hCount == 10'd0) && (vCount == 10'd0);
  assign hit_accept  = (state_reg == PLAY) && hit_valid &&
                       (hit_idx < 6'(NUM_BRICKS)) && vis_ext[hit_idx];

  always_comb begin
    state_next       = state_reg;
    frame_cnt_next   = frame_cnt_reg;
    visible_next     = visible_reg;
    bricks_left_next = bricks_left_reg;
    case (state_reg)
      PLAY: begin
        if (hit_accept) begin
          visible_next     = visible_reg & ~(NUM_BRICKS'(1) << hit_idx);
          bricks_left_next = bricks_left_reg - 6'd1;
          if (bricks_left_reg == 6'd1) begin
            state_next     = FLASH;
            frame_cnt_next = '0;
          end
        end
      end
      FLASH: begin
        if (frame_start) begin
          if (frame_cnt_reg == FC_W'(FLASH_FRAMES - 1)) state_next = REFILL;
          else frame_cnt_next = frame_cnt_reg + FC_W'(1);
        end
      end
      REFILL: begin
        state_next       = PLAY;
        visible_next     = '1;
        bricks_left_next = 6'(NUM_BRICKS);
      end
      default: state_next = PLAY;
    endcase
  end

  always_comb begin
    pix_idx     = 6'(int'(loc_row) * NUM_X + int'(loc_col));
    draw_next   = in_brick && ((state_reg == FLASH) ? !frame_cnt_reg[BLINK_SHIFT-1]
                                                    : vis_ext[pix_idx]);
    colour_next = (state_reg == FLASH) ? WHITE : row_colour(loc_row);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= PLAY;
      frame_cnt_reg   <= '0;
      visible_reg     <= '1;
      bricks_left_reg <= 6'(NUM_BRICKS);
      level_clear_reg <= 1'b0;
      brick_on_reg    <= 1'b0;
      brick_pixel_reg <= BLACK;
    end else begin
      state_reg       <= state_next;
      frame_cnt_reg   <= frame_cnt_next;
      visible_reg     <= visible_next;
      bricks_left_reg <= bricks_left_next;
      level_clear_reg <= (state_next == FLASH) && (state_reg != FLASH);
      brick_on_reg    <= draw_next;
      brick_pixel_reg <= draw_next ? colour_next : BLACK;
    end
  end

  assign visible     = visible_reg;
  assign bricks_left = bricks_left_reg;
  assign level_clear = level_clear_reg;
  assign brick_on    = brick_on_reg;
  assign brick_pixel = brick_pixel_reg;

endmodule

// File: tb/tb_brick_field.sv
// Directed bench for brick_field: hits, rendering, level clear, flash/refill and reset.
module tb_brick_field;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  hCount, vCount;
  logic        hit_valid;
  logic [5:0]  hit_idx;
  logic [55:0] visible;
  logic        brick_on;
  logic [11:0] brick_pixel;
  logic [5:0]  bricks_left;
  logic        level_clear;

  int n_compared   = 0;
  int n_mismatched = 0;
  int lc_count     = 0;
  int lc_base;

  localparam logic [55:0] ALL_ONES = 56'hFF_FFFF_FFFF_FFFF;

  brick_field dut (
    .clk         (clk),
    .rst         (rst),
    .hCount      (hCount),
    .vCount      (vCount),
    .hit_valid   (hit_valid),
    .hit_idx     (hit_idx),
    .visible     (visible),
    .brick_on    (brick_on),
    .brick_pixel (brick_pixel),
    .bricks_left (bricks_left),
    .level_clear (level_clear)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (level_clear) lc_count <= lc_count + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pixel(input int h, input int v);
    hCount = 10'(h);
    vCount = 10'(v);
    tick();
    hCount = 10'd5;
    vCount = 10'd5;
  endtask

  task automatic frame_start();
    pixel(0, 0);
  endtask

  task automatic hit(input int idx);
    hit_valid = 1'b1;
    hit_idx   = 6'(idx);
    tick();
    hit_valid = 1'b0;
  endtask

  task automatic check_pixel(input string tag, input int h, input int v,
                             input logic on, input logic [11:0] colour);
    pixel(h, v);
    check({tag, "_on"}, 64'(brick_on), 64'(on));
    check({tag, "_rgb"}, 64'(brick_pixel), 64'(colour));
  endtask

  task automatic clear_all();
    for (int i = 0; i < 56; i++) begin
      hit(i);
      if (i == 55) check("lc_pulse", 64'(level_clear), 64'd1);
    end
    tick();
    check("lc_drop", 64'(level_clear), 64'd0);
    check("flash_left", 64'(bricks_left), 64'd0);
    check("flash_vis", 64'(visible), 64'd0);
  endtask

  initial begin
    rst = 1'b1; hit_valid = 1'b0; hit_idx = '0; hCount = 10'd5; vCount = 10'd5;
    tick(); tick();
    check("rst_vis", 64'(visible), 64'(ALL_ONES));
    check("rst_left", 64'(bricks_left), 64'd56);
    check("rst_on", 64'(brick_on), 64'd0);
    check("rst_rgb", 64'(brick_pixel), 64'd0);
    check("rst_lc", 64'(level_clear), 64'd0);
    rst = 1'b0;

    check_pixel("px_152_150", 152, 150, 1'b1, 12'hF00);
    check_pixel("px_191_169", 191, 169, 1'b1, 12'hF00);
    check_pixel("px_gap_192", 192, 150, 1'b0, 12'h000);
    check_pixel("px_gap_row", 152, 170, 1'b0, 12'h000);
    check_pixel("px_197_175", 197, 175, 1'b1, 12'hF80);
    check_pixel("px_737_225", 737, 225, 1'b1, 12'h0F0);
    check_pixel("px_776_244", 776, 244, 1'b1, 12'h0F0);
    check_pixel("px_777_244", 777, 244, 1'b0, 12'h000);

    hit(15);
    check("hit15_vis", 64'(visible), 64'(56'hFF_FFFF_FFFF_7FFF));
    check("hit15_left", 64'(bricks_left), 64'd55);
    check_pixel("px_hit15", 197, 175, 1'b0, 12'h000);
    hit(15);
    check("rehit15_left", 64'(bricks_left), 64'd55);
    hit(56);
    hit(63);
    check("oor_vis", 64'(visible), 64'(56'hFF_FFFF_FFFF_7FFF));
    check("oor_left", 64'(bricks_left), 64'd55);

    // First level clear: full flash and refill.
    lc_base = lc_count;
    clear_all();
    hit(0);
    check("flash_hit_ign", 64'(bricks_left), 64'd0);
    for (int f = 0; f < 8; f++) begin
      check_pixel($sformatf("flash_f%0d", f), 152, 150, (f < 4), (f < 4) ? 12'hFFF : 12'h000);
      frame_start();
    end
    for (int f = 8; f < 59; f++) frame_start();
    check_pixel("flash_f59", 300, 200, 1'b1, 12'hFFF);
    check("f59_left", 64'(bricks_left), 64'd0);
    frame_start();
    tick();
    check("refill_left", 64'(bricks_left), 64'd56);
    check("refill_vis", 64'(visible), 64'(ALL_ONES));
    check_pixel("play_after", 152, 150, 1'b1, 12'hF00);
    check("lc_count1", 64'(lc_count - lc_base), 64'd1);

    // Second level clear aborted by reset at frame 20.
    lc_base = lc_count;
    clear_all();
    for (int f = 0; f < 20; f++) frame_start();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_vis", 64'(visible), 64'(ALL_ONES));
    check("abort_left", 64'(bricks_left), 64'd56);
    check("abort_lc", 64'(level_clear), 64'd0);
    check_pixel("abort_px", 152, 150, 1'b1, 12'hF00);
    check("lc_count2", 64'(lc_count - lc_base), 64'd1);
    hit(0);
    check("play_hit_left", 64'(bricks_left), 64'd55);

    rst = 1'b1; hit_valid = 1'b1; hit_idx = 6'd3;
    tick();
    rst = 1'b0; hit_valid = 1'b0;
    check("rsthit_vis", 64'(visible), 64'(ALL_ONES));
    check("rsthit_left", 64'(bricks_left), 64'd56);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
